// File: rtl/drop_seq_pkg.sv
// Shared types and constants for the drop sequencer.
// The optional sample watchdog is enabled by defining DROP_SEQ_WATCHDOG_EN.
package drop_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DROP  = 2'd2,
    ST_COOL  = 2'd3
  } state_t;

  localparam int DEF_W = 16;
  localparam int CNT_W = 8;

endpackage

// File: rtl/drop_seq_timer.sv
// Loadable down-counter with a zero flag; one instance times both the drop
// window and the cooldown lockout.
module drop_seq_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/drop_sequencer.sv
// Drop episode sequencer: sample/limit registers, IDLE/ARMED/DROP/COOL FSM,
// saturating episode counter and, with DROP_SEQ_WATCHDOG_EN, a sample watchdog.
module drop_sequencer
  import drop_seq_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int DROP_CYCLES = 8,
  parameter int COOL_CYCLES = 16,
  parameter int HYST        = 2,
  parameter int WDOG_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [W-1:0]     sample_data,
  input  logic             cfg_load,
  input  logic [W-1:0]     cfg_lim,
  input  logic             arm,
  input  logic             disarm,
  output logic [W-1:0]     t_act,
  output logic [W-1:0]     t_lim,
  output logic             drop_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] drop_count,
  output logic             fault
);

  localparam int TMAX = (DROP_CYCLES > COOL_CYCLES) ? DROP_CYCLES : COOL_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_t_act, r_t_lim;
  logic [CNT_W-1:0] r_drop_count;
  logic             w_tmr_load, w_tmr_dec, w_tmr_zero;
  logic [TW-1:0]    w_tmr_val;
  logic             w_episode, w_wdog_trip, w_fault, w_early;
  logic [W:0]       w_lim_hyst;

  // Extra bit keeps t_lim + HYST from wrapping near full scale.
  assign w_lim_hyst = {1'b0, r_t_lim} + (W+1)'(HYST);
  assign w_early    = ({1'b0, r_t_act} >= w_lim_hyst);

  drop_seq_timer #(.TW(TW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .i_dec     (w_tmr_dec),
    .o_zero    (w_tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_t_act      <= '0;
      r_t_lim      <= '0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (sample_valid) r_t_act <= sample_data;
      if (cfg_load && (r_state == ST_IDLE)) r_t_lim <= cfg_lim;
      if (w_episode && (r_drop_count != '1)) r_drop_count <= r_drop_count + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_tmr_dec   = 1'b0;
    w_episode   = 1'b0;
    if (disarm || w_wdog_trip) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm && !w_fault) w_state_nxt = ST_ARMED;
        end
        ST_ARMED: begin
          if (r_t_act < r_t_lim) begin
            w_state_nxt = ST_DROP;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TW'(DROP_CYCLES - 1);
          end
        end
        ST_DROP: begin
          if (w_tmr_zero || w_early) begin
            w_state_nxt = ST_COOL;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TW'(COOL_CYCLES - 1);
            w_episode   = 1'b1;
          end else begin
            w_tmr_dec = 1'b1;
          end
        end
        default: begin
          if (w_tmr_zero) w_state_nxt = ST_ARMED;
          else            w_tmr_dec   = 1'b1;
        end
      endcase
    end
  end

`ifdef DROP_SEQ_WATCHDOG_EN
  localparam int WDW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WDW-1:0] r_wdog;
  logic           r_fault;

  assign w_wdog_trip = (r_state != ST_IDLE) && (r_wdog == WDW'(WDOG_CYCLES - 1));
  assign w_fault     = r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog  <= '0;
      r_fault <= 1'b0;
    end else begin
      if (sample_valid || (r_state == ST_IDLE)) r_wdog <= '0;
      else if (!w_wdog_trip)                    r_wdog <= r_wdog + 1'b1;
      if (w_wdog_trip)                                 r_fault <= 1'b1;
      else if (cfg_load && (r_state == ST_IDLE))       r_fault <= 1'b0;
    end
  end
`else
  logic w_unused_wdog;
  assign w_unused_wdog = (WDOG_CYCLES > 0);
  assign w_wdog_trip   = 1'b0;
  assign w_fault       = 1'b0;
`endif

  assign t_act      = r_t_act;
  assign t_lim      = r_t_lim;
  assign state      = r_state;
  assign drop_en    = (r_state == ST_ARMED) || (r_state == ST_DROP);
  assign drop_count = r_drop_count;
  assign fault      = w_fault;

endmodule

// File: tb/tb_drop_sequencer.sv
// Directed bench for drop_sequencer: episode timing, early exit, disarm,
// saturation, boundaries and the watchdog (DROP_SEQ_WATCHDOG_EN) behaviour.
module tb_drop_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        cfg_load;
  logic [15:0] cfg_lim;
  logic        arm;
  logic        disarm;
  logic [15:0] t_act;
  logic [15:0] t_lim;
  logic        drop_en;
  logic [1:0]  state;
  logic [7:0]  drop_count;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  drop_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .cfg_load    (cfg_load),
    .cfg_lim     (cfg_lim),
    .arm         (arm),
    .disarm      (disarm),
    .t_act       (t_act),
    .t_lim       (t_lim),
    .drop_en     (drop_en),
    .state       (state),
    .drop_count  (drop_count),
    .fault       (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample_data = '0; cfg_load = 1'b0;
    cfg_lim = '0; arm = 1'b0; disarm = 1'b0;
    repeat (2) tick();
    check("rst_state",  32'(state), 0);
    check("rst_t_act",  32'(t_act), 0);
    check("rst_t_lim",  32'(t_lim), 0);
    check("rst_drop_en", 32'(drop_en), 0);
    check("rst_count",  32'(drop_count), 0);
    check("rst_fault",  32'(fault), 0);
    rst = 1'b0;
    tick();

    // configure limit and park the temperature above it
    sample_valid = 1'b1; sample_data = 16'd200; cfg_load = 1'b1; cfg_lim = 16'd100;
    tick();
    cfg_load = 1'b0;
    check("cfg_t_lim", 32'(t_lim), 100);
    check("cfg_t_act", 32'(t_act), 200);
    check("cfg_idle",  32'(state), 0);

    arm = 1'b1; disarm = 1'b1;
    tick();
    arm = 1'b0; disarm = 1'b0;
    check("disarm_beats_arm", 32'(state), 0);

    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_state",   32'(state), 1);
    check("arm_drop_en", 32'(drop_en), 1);

    cfg_load = 1'b1; cfg_lim = 16'd50;
    tick();
    cfg_load = 1'b0;
    check("cfg_in_armed_ignored", 32'(t_lim), 100);

    sample_data = 16'd100;
    tick(); tick();
    check("equal_no_drop", 32'(state), 1);

    // full episode
    sample_data = 16'd90;
    tick();
    check("latency_still_armed", 32'(state), 1);
    tick();
    check("drop_entry",   32'(state), 2);
    check("drop_entry_en", 32'(drop_en), 1);
    repeat (7) tick();
    check("drop_8th_cycle", 32'(state), 2);
    tick();
    check("cool_entry",    32'(state), 3);
    check("cool_drop_en",  32'(drop_en), 0);
    check("count_after_1", 32'(drop_count), 1);
    sample_data = 16'd200;
    repeat (15) tick();
    check("cool_16th_cycle", 32'(state), 3);
    tick();
    check("rearmed",    32'(state), 1);
    check("rearmed_en", 32'(drop_en), 1);

    // early exit with hysteresis
    sample_data = 16'd90;
    tick(); tick();
    check("early_drop_entry", 32'(state), 2);
    sample_data = 16'd101;
    tick(); tick();
    check("hyst_101_stays", 32'(state), 2);
    sample_data = 16'd102;
    tick();
    check("hyst_102_latency", 32'(state), 2);
    tick();
    check("hyst_102_exit",  32'(state), 3);
    check("count_after_2",  32'(drop_count), 2);
    sample_data = 16'd200;
    repeat (16) tick();
    check("early_rearmed", 32'(state), 1);

    // disarm during drop
    sample_data = 16'd90;
    tick(); tick();
    check("disarm_drop_entry", 32'(state), 2);
    sample_data = 16'd200; disarm = 1'b1;
    tick();
    disarm = 1'b0;
    check("disarm_idle",    32'(state), 0);
    check("disarm_drop_en", 32'(drop_en), 0);
    check("disarm_count",   32'(drop_count), 2);

    // full-scale limit: no wrap of t_lim + HYST
    cfg_load = 1'b1; cfg_lim = 16'hFFFF; sample_data = 16'hFFFE;
    tick();
    cfg_load = 1'b0;
    check("max_lim", 32'(t_lim), 32'hFFFF);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("max_armed", 32'(state), 1);
    sample_data = 16'hFFFF;
    tick();
    check("max_drop_entry", 32'(state), 2);
    repeat (7) tick();
    check("max_no_early_exit", 32'(state), 2);
    tick();
    check("max_timeout_cool", 32'(state), 3);
    check("count_after_3",    32'(drop_count), 3);

    // saturation: back-to-back 25-cycle episodes
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    cfg_load = 1'b1; cfg_lim = 16'd100; sample_data = 16'd90;
    tick();
    cfg_load = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (250) tick();
    check("count_after_13", 32'(drop_count), 13);
    check("period_armed",   32'(state), 1);
    repeat (25 * 251) tick();
    check("count_saturated", 32'(drop_count), 255);

    // asynchronous reset mid-episode
    repeat (5) tick();
    check("pre_reset_drop", 32'(state), 2);
    rst = 1'b1;
    #2;
    check("async_rst_state", 32'(state), 0);
    check("async_rst_count", 32'(drop_count), 0);
    check("async_rst_en",    32'(drop_en), 0);
    rst = 1'b0;
    tick();

    // watchdog: armed with no samples (t_lim is 0 so no drop can start)
    sample_valid = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    check("wdog_armed", 32'(state), 1);
    repeat (63) tick();
    check("wdog_63_armed", 32'(state), 1);
    tick();
`ifdef DROP_SEQ_WATCHDOG_EN
    check("wdog_trip_idle", 32'(state), 0);
    check("wdog_fault",     32'(fault), 1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("wdog_arm_blocked", 32'(state), 0);
    cfg_load = 1'b1; cfg_lim = 16'd0;
    tick();
    cfg_load = 1'b0;
    check("wdog_fault_cleared", 32'(fault), 0);
`else
    check("nowdog_still_armed", 32'(state), 1);
    check("nowdog_fault",       32'(fault), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/drop_sequencer.md
# drop_sequencer

Sequencing controller for the thermostat display/drop unit. Registers incoming temperature samples and the configured limit, drives `t_act`, `t_lim` and `drop_en` into the display/drop unit, and bounds each drop episode with a fixed-length drop window followed by a cooldown lockout. Sits between the sensor/config interface and the display/drop unit, and keeps a saturating count of drop episodes.

## Interface
Parameters:
- `W`, 16: temperature width.
- `DROP_CYCLES`, 8: maximum drop window length in cycles (≥1).
- `COOL_CYCLES`, 16: cooldown lockout length in cycles (≥1).
- `HYST`, 2: hysteresis added to `t_lim` for early drop exit.
- `WDOG_CYCLES`, 64: sample watchdog timeout (used only with `DROP_SEQ_WATCHDOG_EN`).

Ports:
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `sample_valid` in 1: `sample_data` is valid this cycle.
- `sample_data` in W: temperature sample.
- `cfg_load` in 1: load `cfg_lim`. Honoured only in IDLE.
- `cfg_lim` in W: new limit.
- `arm` in 1: level/pulse request to leave IDLE.
- `disarm` in 1: force return to IDLE.
- `t_act` out W: registered current temperature.
- `t_lim` out W: registered limit.
- `drop_en` out 1: enable to the display/drop unit.
- `state` out 2: IDLE=0, ARMED=1, DROP=2, COOL=3.
- `drop_count` out 8: completed drop episodes, saturates at 255.
- `fault` out 1: sticky watchdog fault.

## Operation
- `t_act` captures `sample_data` on any cycle with `sample_valid`, in every state. `t_lim` captures `cfg_lim` on `cfg_load` in IDLE only. `cfg_load` in other states is ignored.
- FSM, evaluated on registered `t_act`/`t_lim`. Transition priority runs top to bottom:
  - Any state, `disarm` → IDLE. `disarm` beats `arm`.
  - IDLE: `drop_en`=0. `arm` → ARMED, but not while `fault`=1.
  - ARMED: `drop_en`=1. `t_act < t_lim` → DROP, timer loads `DROP_CYCLES-1`.
  - DROP: `drop_en`=1. Timer decrements each cycle.
    - Timer==0 → COOL.
    - Otherwise `t_act >= t_lim + HYST` → COOL early. The sum is computed in W+1 bits, so there is no wrap.
    - On either exit: timer loads `COOL_CYCLES-1` and `drop_count` increments, saturating.
  - COOL: `drop_en`=0. Timer decrements. Timer==0 → ARMED.
- `disarm` during DROP goes to IDLE without incrementing `drop_count`.
- Unsigned compares throughout.

## Timing
- Reset values: `state`=IDLE, `t_act`=0, `t_lim`=0, `drop_en`=0, `drop_count`=0, `fault`=0, timer=0.
- All outputs are registered. `drop_en` is decoded from the state register, so it changes in the same cycle as `state`.
- Sample-to-decision latency is 1 cycle. A sample captured at edge N is compared at edge N+1. A `sample_valid` coinciding with a transition edge does not affect that transition.
- DROP lasts exactly `DROP_CYCLES` cycles unless it exits early (minimum 1 cycle). COOL lasts exactly `COOL_CYCLES` cycles.
- Reset asserted mid-episode clears everything immediately (asynchronous). No episode is counted.

## Configuration
Macro: `DROP_SEQ_WATCHDOG_EN`.
- Defined:
  - A counter clears on every `sample_valid` and while in IDLE.
  - It counts in the other states.
  - On reaching `WDOG_CYCLES-1` without a sample: go to IDLE and set `fault`=1.
  - `fault` clears only on `rst` or a `cfg_load` in IDLE.
- Undefined: no counter; `fault` is tied 0.

## Structure
- Package `drop_seq_pkg` holds:
  - the state enum typedef and its encodings (IDLE/ARMED/DROP/COOL);
  - the default width constant;
  - the `drop_count` width (8).
- Sub-module `drop_seq_timer`: loadable down-counter with a `zero` flag, shared by the DROP and COOL windows.
- Top level holds the FSM, the sample/limit registers, the episode counter and the optional watchdog.

## Test plan
- Reset then idle:
  - Outputs are all 0 and `state`=0.
  - `cfg_load` with `cfg_lim`=100 → `t_lim`=100 next cycle.
  - `arm` → `state`=1, `drop_en`=1.
- Full drop episode, `t_lim`=100, armed, sample 90:
  - DROP begins 1 cycle after capture.
  - `drop_en`=1 for 8 cycles, then COOL for 16 cycles with `drop_en`=0, then ARMED.
  - `drop_count`=1.
- Early exit: in DROP, sample 102 (=`t_lim`+HYST) → COOL on the next edge. `drop_count` increments. Sample 101 does not exit early.
- `disarm` conflicts:
  - `disarm` and `arm` in the same cycle from IDLE → stays IDLE.
  - `disarm` in DROP → IDLE, `drop_count` unchanged.
  - `cfg_load` in ARMED → `t_lim` unchanged.
- Saturation and boundaries:
  - 256 episodes → `drop_count`=255.
  - `t_lim`=16'hFFFF with `HYST`=2 → no early exit (no wrap).
  - `t_act`=`t_lim` in ARMED → no DROP.
- Watchdog (macro defined): armed with no samples for 64 cycles → IDLE, `fault`=1, `arm` ignored. `cfg_load` in IDLE clears `fault`. With the macro undefined, `fault` stays 0.
